allo_sequencer: RTL and testbench

- Parametrised next-generation allophone controller/sequencer for the Speech256 synthesis chain.
- Buffers incoming allophone codes in an internal FIFO and walks a control-program ROM through an external synchronous port.
- Serves pitch, amplitude and duration records to the source, and streams 2*N_SECTIONS filter coefficients to the filter bank.
- Beyond the single-allophone controller, it adds: input queueing, a configurable section count and address width, abort/flush, and busy/level status.

---
 rtl/allo_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_allo_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/allo_sequencer.sv
// Allophone sequencer for the Speech256 chain. Queues allophone codes in a
// small FIFO, walks the control-program ROM over a synchronous read port and
// serves amplitude/period/duration records plus filter coefficient bursts.
module allo_sequencer #(
  parameter int          ALLO_W     = 6,
  parameter int          ADDR_W     = 12,
  parameter int          FIFO_DEPTH = 4,
  parameter int          N_SECTIONS = 6,
  parameter logic [3:0]  CMD_END    = 4'hF,
  parameter logic [3:0]  CMD_COEF   = 4'h2,
  localparam int         NCOEF      = 2 * N_SECTIONS,
  localparam int         IDX_W      = $clog2(NCOEF),
  localparam int         PTR_W      = $clog2(FIFO_DEPTH),
  localparam int         LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ALLO_W-1:0] data_in,
  input  logic              data_stb,
  output logic              ldq,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              period_done_in,
  output logic [7:0]        period_out,
  output logic [15:0]       amp_out,
  output logic [7:0]        coeff_out,
  output logic [IDX_W-1:0]  coeff_idx,
  output logic              coeff_stb,
  output logic              clear_states,
  output logic              busy,
  output logic [LVL_W-1:0]  fifo_level
);

  typedef enum logic [3:0] {
    S_IDLE, S_TBL_MSB, S_TBL_LSB, S_JUMP, S_CMD,
    S_AMP1, S_AMP2, S_DUR, S_PER, S_GATE, S_COEF
  } state_t;

  localparam logic [IDX_W-1:0] COEF_LAST = IDX_W'(NCOEF - 1);

  state_t              state;
  logic [ALLO_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [LVL_W-1:0]    level;
  logic                fifo_full, fifo_empty, push, pop;

  logic [ALLO_W-1:0]   cur_allo;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-9:0]   msb_q;
  logic [3:0]          cmd_q;
  logic [15:0]         amp_stg;
  logic [7:0]          dur_stg, per_stg;
  logic [7:0]          duration, dur_cnt;
  logic [IDX_W-1:0]    coef_cnt;
  logic [ADDR_W-1:0]   head_tbl, cur_odd, jump_addr;

  assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  // abort wins over both FIFO ports so a flush cannot race a push or pop
  assign push       = data_stb && !fifo_full && !abort;
  assign pop        = (state == S_IDLE) && !fifo_empty && !abort;
  assign ldq        = !fifo_full;
  assign fifo_level = level;
  assign busy       = (state != S_IDLE) || (level != '0);

  // Table entry A lives at {0, A, 0} (MSB) and {0, A, 1} (LSB)
  assign head_tbl  = ADDR_W'({fifo_mem[rd_ptr], 1'b0});
  assign cur_odd   = ADDR_W'({cur_allo, 1'b1});
  assign jump_addr = {msb_q, rom_data};

  // The LSB byte arrives in JUMP; present the jump target directly so the
  // command byte is on rom_data in the very next cycle.
  assign rom_addr = (state == S_JUMP) ? jump_addr : addr_q;

  // FIFO pointers and fill level; abort flushes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // FIFO storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= data_in;
  end

  // Sequencer FSM: every ROM-consuming state reads the byte addressed in the
  // previous cycle and advances addr_q; PER and a waiting GATE hold it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cur_allo     <= '0;
      addr_q       <= '0;
      msb_q        <= '0;
      cmd_q        <= '0;
      amp_stg      <= '0;
      dur_stg      <= '0;
      per_stg      <= '0;
      duration     <= '0;
      dur_cnt      <= '0;
      coef_cnt     <= '0;
      period_out   <= 8'd1;
      amp_out      <= '0;
      coeff_out    <= '0;
      coeff_idx    <= '0;
      coeff_stb    <= 1'b0;
      clear_states <= 1'b0;
    end else if (abort) begin
      state        <= S_IDLE;
      duration     <= '0;
      dur_cnt      <= '0;
      amp_out      <= '0;
      coeff_stb    <= 1'b0;
      clear_states <= 1'b1;
    end else begin
      clear_states <= 1'b0;
      coeff_stb    <= 1'b0;
      // duration counter saturates at the current duration
      if (period_done_in && (dur_cnt != duration)) dur_cnt <= dur_cnt + 8'd1;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            cur_allo <= fifo_mem[rd_ptr];
            addr_q   <= head_tbl;
            state    <= S_TBL_MSB;
          end
        end
        S_TBL_MSB: begin
          addr_q <= cur_odd;
          state  <= S_TBL_LSB;
        end
        S_TBL_LSB: begin
          msb_q <= rom_data[ADDR_W-9:0];
          state <= S_JUMP;
        end
        S_JUMP: begin
          addr_q <= jump_addr + ADDR_W'(1);
          state  <= S_CMD;
        end
        S_CMD: begin
          cmd_q  <= rom_data[3:0];
          addr_q <= addr_q + ADDR_W'(1);
          state  <= (rom_data[3:0] == CMD_END) ? S_IDLE : S_AMP1;
        end
        S_AMP1: begin
          amp_stg[7:0] <= rom_data;
          addr_q       <= addr_q + ADDR_W'(1);
          state        <= S_AMP2;
        end
        S_AMP2: begin
          amp_stg[15:8] <= rom_data;
          addr_q        <= addr_q + ADDR_W'(1);
          state         <= S_DUR;
        end
        S_DUR: begin
          dur_stg <= rom_data;
          addr_q  <= addr_q + ADDR_W'(1);
          state   <= S_PER;
        end
        S_PER: begin
          per_stg <= rom_data;
          state   <= S_GATE;
        end
        S_GATE: begin
          if (dur_cnt == duration) begin
            amp_out    <= amp_stg;
            period_out <= per_stg;
            duration   <= dur_stg;
            dur_cnt    <= '0;
            addr_q     <= addr_q + ADDR_W'(1);
            if (cmd_q == CMD_COEF) begin
              clear_states <= 1'b1;
              coef_cnt     <= '0;
              state        <= S_COEF;
            end else begin
              state <= S_CMD;
            end
          end
        end
        S_COEF: begin
          coeff_out <= rom_data;
          coeff_idx <= coef_cnt;
          coeff_stb <= 1'b1;
          addr_q    <= addr_q + ADDR_W'(1);
          if (coef_cnt == COEF_LAST) state <= S_CMD;
          else coef_cnt <= coef_cnt + IDX_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_allo_sequencer.sv
// Directed bench for allo_sequencer with a registered ROM model.
module tb_allo_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  data_in = '0;
  logic        data_stb = 1'b0;
  logic        ldq;
  logic        abort = 1'b0;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic        period_done_in = 1'b0;
  logic [7:0]  period_out;
  logic [15:0] amp_out;
  logic [7:0]  coeff_out;
  logic [3:0]  coeff_idx;
  logic        coeff_stb;
  logic        clear_states;
  logic        busy;
  logic [2:0]  fifo_level;

  logic [7:0]  rom [4096];
  int          passed = 0;
  int          total  = 0;
  int          fails  = 0;
  logic [15:0] amp_q[$];
  logic [15:0] last_amp = '0;

  allo_sequencer dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_stb(data_stb), .ldq(ldq),
    .abort(abort), .rom_addr(rom_addr), .rom_data(rom_data),
    .period_done_in(period_done_in), .period_out(period_out), .amp_out(amp_out),
    .coeff_out(coeff_out), .coeff_idx(coeff_idx), .coeff_stb(coeff_stb),
    .clear_states(clear_states), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // synchronous ROM: data one cycle after address
  always @(posedge clk) rom_data <= rom[rom_addr];

  // record every change of amp_out
  always @(negedge clk) begin
    if (amp_out !== last_amp) begin
      amp_q.push_back(amp_out);
      last_amp <= amp_out;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] a);
    data_in  = a;
    data_stb = 1'b1;
    tick(1);
    data_stb = 1'b0;
  endtask

  task automatic pulse();
    period_done_in = 1'b1;
    tick(1);
    period_done_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic put_rec(input int a, input logic [3:0] cmd, input logic [15:0] amp,
                         input logic [7:0] dur, input logic [7:0] per);
    rom[a]   = {4'h0, cmd};
    rom[a+1] = amp[7:0];
    rom[a+2] = amp[15:8];
    rom[a+3] = dur;
    rom[a+4] = per;
  endtask

  initial begin
    int base;
    logic [15:0] got;
    logic [15:0] exp_amp [5];
    for (int i = 0; i < 4096; i++) rom[i] = 8'hFF;
    // allophone table
    rom[10] = 8'h01; rom[11] = 8'h00;   // A=5 -> 0x100
    rom[12] = 8'h02; rom[13] = 8'h00;   // A=6 -> 0x200
    rom[14] = 8'h03; rom[15] = 8'h00;   // A=7 -> 0x300
    for (int c = 8; c < 12; c++) begin
      rom[2*c]   = 8'h04;
      rom[2*c+1] = 8'((c - 8) * 16);
      put_rec(12'h400 + (c - 8) * 16, 4'h1, 16'h0800 | 16'(c), 8'd0, 8'(c));
    end
    put_rec(12'h100, 4'h1, 16'h1234, 8'd3, 8'd80);
    put_rec(12'h200, 4'h1, 16'h1111, 8'd3, 8'd10);
    put_rec(12'h205, 4'h1, 16'h2222, 8'd2, 8'd20);
    put_rec(12'h300, 4'h2, 16'h0ABC, 8'd1, 8'd50);
    for (int k = 0; k < 12; k++) rom[12'h305 + k] = 8'(8'h10 + k);

    do_reset();
    check("rst_period", period_out, 8'd1);
    check("rst_amp", amp_out, 16'h0);
    check("rst_coeff", {coeff_stb, clear_states, coeff_idx, coeff_out}, 14'h0);
    check("rst_ldq", ldq, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_level", fifo_level, 3'd0);
    check("rst_addr", rom_addr, 12'h0);

    // single record, served without waiting
    push(6'd5);
    tick(9);
    check("t1_amp_before_gate", amp_out, 16'h0);
    tick(1);
    check("t1_amp", amp_out, 16'h1234);
    check("t1_period", period_out, 8'd80);
    check("t1_busy_run", busy, 1'b1);
    tick(1);
    check("t1_busy_end", busy, 1'b0);

    // duration gating and saturation
    do_reset();
    push(6'd6);
    tick(10);
    check("t2_rec1_amp", amp_out, 16'h1111);
    check("t2_rec1_per", period_out, 8'd10);
    pulse();
    tick(8);
    check("t2_wait1", amp_out, 16'h1111);
    pulse();
    check("t2_wait2", amp_out, 16'h1111);
    pulse();
    check("t2_wait3", amp_out, 16'h1111);
    tick(1);
    check("t2_rec2_amp", amp_out, 16'h2222);
    check("t2_rec2_per", period_out, 8'd20);
    tick(2);
    check("t2_idle", busy, 1'b0);
    for (int i = 0; i < 5; i++) begin
      pulse();
      tick(1);
    end
    push(6'd5);
    tick(9);
    check("t2_sat_before", amp_out, 16'h2222);
    tick(1);
    check("t2_sat_served", amp_out, 16'h1234);

    // coefficient burst
    do_reset();
    push(6'd7);
    tick(9);
    check("t3_clr_before", clear_states, 1'b0);
    tick(1);
    check("t3_clr_pulse", {clear_states, coeff_stb}, 2'b10);
    check("t3_amp", amp_out, 16'h0ABC);
    check("t3_per", period_out, 8'd50);
    for (int k = 0; k < 12; k++) begin
      tick(1);
      check($sformatf("t3_coef%0d", k), {clear_states, coeff_stb, coeff_idx, coeff_out},
            {1'b0, 1'b1, 4'(k), 8'(8'h10 + k)});
    end
    tick(1);
    check("t3_stb_off", coeff_stb, 1'b0);
    check("t3_busy_end", busy, 1'b0);

    // FIFO fill while waiting in GATE; play-out order
    do_reset();
    push(6'd6);
    tick(20);
    base = amp_q.size();
    for (int c = 8; c < 12; c++) push(6'(c));
    check("t4_level_full", fifo_level, 3'd4);
    check("t4_ldq_full", ldq, 1'b0);
    push(6'd12);
    push(6'd13);
    check("t4_level_drop", fifo_level, 3'd4);
    check("t4_ldq_drop", ldq, 1'b0);
    for (int i = 0; i < 12; i++) begin
      pulse();
      tick(2);
    end
    tick(80);
    check("t4_count", amp_q.size() - base, 5);
    exp_amp = '{16'h2222, 16'h0808, 16'h0809, 16'h080A, 16'h080B};
    for (int i = 0; i < 5; i++) begin
      got = (base + i < amp_q.size()) ? amp_q[base + i] : 16'hDEAD;
      check($sformatf("t4_order%0d", i), got, exp_amp[i]);
    end
    check("t4_empty", {busy, fifo_level}, 4'h0);

    // abort mid-burst
    do_reset();
    push(6'd7);
    push(6'd5);
    tick(15);
    check("t5_idx5", {coeff_stb, coeff_idx, coeff_out}, {1'b1, 4'd5, 8'h15});
    check("t5_level_pre", fifo_level, 3'd1);
    abort    = 1'b1;
    data_in  = 6'd9;
    data_stb = 1'b1;
    tick(1);
    abort    = 1'b0;
    data_stb = 1'b0;
    check("t5_stb_stop", coeff_stb, 1'b0);
    check("t5_clr", clear_states, 1'b1);
    check("t5_level", fifo_level, 3'd0);
    check("t5_amp", amp_out, 16'h0);
    check("t5_per_held", period_out, 8'd50);
    check("t5_idle", busy, 1'b0);
    tick(1);
    check("t5_clr_end", clear_states, 1'b0);
    tick(20);
    check("t5_quiet", {busy, coeff_stb, amp_out}, 18'h0);

    // reset during GATE with queued allophones
    do_reset();
    push(6'd6);
    push(6'd8);
    push(6'd9);
    tick(18);
    check("t6_level_pre", fifo_level, 3'd2);
    check("t6_amp_pre", amp_out, 16'h1111);
    #3;
    rst = 1'b1;
    #1;
    check("t6_async_amp", amp_out, 16'h0);
    check("t6_async_per", period_out, 8'd1);
    check("t6_async_fifo", {ldq, busy, fifo_level}, {1'b1, 1'b0, 3'd0});
    check("t6_async_misc", {rom_addr, coeff_stb, clear_states}, 14'h0);
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pulse();
      tick(2);
    end
    tick(30);
    check("t6_no_replay", {busy, amp_out}, 17'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
